// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and op-class helpers shared by the
// execute-stage ALU (alu_muldiv) and its iterative mul/div unit.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_ADDU  = 5'd1,
    OP_SUB   = 5'd2,
    OP_SUBU  = 5'd3,
    OP_AND   = 5'd4,
    OP_OR    = 5'd5,
    OP_NOR   = 5'd6,
    OP_XOR   = 5'd7,
    OP_SLL   = 5'd8,
    OP_SRL   = 5'd9,
    OP_SRA   = 5'd10,
    OP_SLT   = 5'd11,
    OP_SLTU  = 5'd12,
    OP_LUI   = 5'd13,
    OP_MFHI  = 5'd14,
    OP_MFLO  = 5'd15,
    OP_MTHI  = 5'd16,
    OP_MTLO  = 5'd17,
    OP_MULT  = 5'd18,
    OP_MULTU = 5'd19,
    OP_DIV   = 5'd20,
    OP_DIVU  = 5'd21
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle multiply (shift-add) / divide (restoring)
// on operand magnitudes, with sign fix-up applied to the final step.
//   start        : load operands (a, b) and mode; runs WIDTH iterations
//   is_div/is_sgn: mode latched at start
//   done         : high in the cycle whose iteration is the last one;
//                  hi_out/lo_out/dbz are the final values in that cycle
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  import alu_pkg::*;

  localparam int CW = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             negp_q, negp_d;   // negate product / quotient
  logic             negr_q, negr_d;   // negate remainder (dividend sign)
  logic [WIDTH-1:0] a_q, a_d;         // raw dividend, returned on /0
  logic [WIDTH-1:0] b_q, b_d;         // multiplicand / divisor magnitude
  logic [2*WIDTH-1:0] p_q, p_d;       // {acc/remainder, multiplier/quotient}

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, step, prod;
  logic [WIDTH-1:0]   quo, rem;

  assign a_mag = (is_sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_sgn && b[WIDTH-1]) ? -b : b;

  // Multiply: add multiplicand into the top half when the LSB is set,
  // then shift the whole product register right by one.
  assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
  assign mul_nxt = {mul_sum, p_q[WIDTH-1:1]};

  // Divide: shift next dividend bit into the remainder, trial-subtract.
  // Remainder stays < divisor, so bit WIDTH of the difference is the sign.
  assign div_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_nxt  = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

  assign step = div_q ? div_nxt : mul_nxt;
  assign prod = negp_q ? -step : step;
  assign quo  = negp_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
  assign rem  = negr_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];

  assign done = busy_q && (cnt_q == '0);
  assign dbz  = div_q && (b_q == '0);

  always_comb begin
    hi_out = prod[2*WIDTH-1:WIDTH];
    lo_out = prod[WIDTH-1:0];
    if (div_q) begin
      hi_out = dbz ? a_q : rem;
      lo_out = dbz ? '1  : quo;
    end
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    negp_d = negp_q;
    negr_d = negr_q;
    a_d    = a_q;
    b_d    = b_q;
    p_d    = p_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(WIDTH - 1);
      div_d  = is_div;
      negp_d = is_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      negr_d = is_sgn && a[WIDTH-1];
      a_d    = a;
      b_d    = b_mag;
      p_d    = {{WIDTH{1'b0}}, a_mag};
    end else if (busy_q) begin
      p_d   = step;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      negp_q <= 1'b0;
      negr_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      negp_q <= negp_d;
      negr_q <= negr_d;
      a_q    <= a_d;
      b_q    <= b_d;
      p_q    <= p_d;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU with registered result/flags, valid/ready
// issue, architectural HI/LO and an iterative mul/div unit.
//   in_valid/in_ready : issue handshake (ready only in IDLE)
//   op, data1, data2, shamt : operation and operands (rs, rt)
//   out_valid : one-cycle completion pulse; result/zero/overflow/div_by_zero
//               hold their last value otherwise
//   hi, lo    : architectural HI/LO registers
module alu_muldiv #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         op,
  input  logic [WIDTH-1:0]   data1,
  input  logic [WIDTH-1:0]   data2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               div_by_zero,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);
  import alu_pkg::*;

  localparam int HW = WIDTH / 2;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d;
  logic             out_valid_q, out_valid_d;

  logic             accept, md_start, md_done, md_dbz;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [WIDTH-1:0] alu_res, sum, diff;
  logic             alu_ovf;

  assign in_ready    = (state_q == IDLE);
  assign accept      = in_valid && in_ready;
  assign md_start    = accept && is_multicycle(op);
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (is_div(op)),
    .is_sgn (is_signed(op)),
    .a      (data1),
    .b      (data2),
    .done   (md_done),
    .dbz    (md_dbz),
    .hi_out (md_hi),
    .lo_out (md_lo)
  );

  assign sum  = data1 + data2;
  assign diff = data1 - data2;

  // Single-cycle datapath. Shifts operate on rt (data2).
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (data1[WIDTH-1] == data2[WIDTH-1]) && (sum[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_ADDU: alu_res = sum;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (data1[WIDTH-1] != data2[WIDTH-1]) && (diff[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_SUBU: alu_res = diff;
      OP_AND:  alu_res = data1 & data2;
      OP_OR:   alu_res = data1 | data2;
      OP_NOR:  alu_res = ~(data1 | data2);
      OP_XOR:  alu_res = data1 ^ data2;
      OP_SLL:  alu_res = data2 << shamt;
      OP_SRL:  alu_res = data2 >> shamt;
      OP_SRA:  alu_res = $signed(data2) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (data1 < data2)};
      OP_LUI:  alu_res = {data2[HW-1:0], {HW{1'b0}}};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      OP_MTHI, OP_MTLO: alu_res = data1;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_multicycle(op)) begin
            state_d = BUSY;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            ovf_d       = alu_ovf;
            dbz_d       = 1'b0;
            if (op == OP_MTHI) hi_d = data1;
            if (op == OP_MTLO) lo_d = data1;
          end
        end
      end
      // Last iteration's value lands on HI/LO at the edge entering DONE,
      // so they read updated for the whole DONE cycle.
      BUSY: begin
        if (md_done) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          hi_d        = md_hi;
          lo_d        = md_lo;
          result_d    = md_lo;
          zero_d      = (md_lo == '0);
          ovf_d       = 1'b0;
          dbz_d       = md_dbz;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors for alu_muldiv at WIDTH=32, plus a
// WIDTH=16 instance for the narrow multiply case.
module tb_alu_muldiv;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // WIDTH = 32 instance
  logic        in_valid, in_ready, out_valid, zero, overflow, dbz;
  logic [4:0]  op;
  logic [31:0] data1, data2, result, hi, lo;
  logic [4:0]  shamt;

  alu_muldiv #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .data1(data1), .data2(data2), .shamt(shamt),
    .out_valid(out_valid), .result(result), .zero(zero), .overflow(overflow),
    .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  // WIDTH = 16 instance
  logic        v16, rdy16, ov16, z16, of16, dz16;
  logic [4:0]  op16;
  logic [15:0] a16, b16, res16, hi16, lo16;
  logic [3:0]  sh16;

  alu_muldiv #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(v16), .in_ready(rdy16),
    .op(op16), .data1(a16), .data2(b16), .shamt(sh16),
    .out_valid(ov16), .result(res16), .zero(z16), .overflow(of16),
    .div_by_zero(dz16), .hi(hi16), .lo(lo16)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op when ready; returns in cycle T+1 (1 ns after the accept edge).
  task automatic issue(input logic [4:0] o, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [4:0] sh);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
    op = o; data1 = d1; data2 = d2; shamt = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Multi-cycle op: returns the cycle offset of out_valid and the number of
  // BUSY cycles in which in_ready was seen high. Optionally keeps in_valid
  // asserted with an MTHI during BUSY.
  task automatic mc(input logic [4:0] o, input logic [31:0] d1, input logic [31:0] d2,
                    input bit hold, output int cyc, output int rdy_hi);
    issue(o, d1, d2, 5'd0);
    if (hold) begin
      op = OP_MTHI; data1 = 32'h0000_0BAD; in_valid = 1'b1;
    end
    cyc = 1; rdy_hi = 0;
    while (!out_valid && cyc < 60) begin
      if (in_ready) rdy_hi++;
      @(posedge clk); #1; cyc++;
    end
    if (in_ready) rdy_hi++;
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, rh, seen;
    reset = 1'b1; in_valid = 1'b0; op = '0; data1 = '0; data2 = '0; shamt = '0;
    v16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; sh16 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({zero, overflow, dbz}), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_res", 64'(result), 64'h8000_0000);
    chk("add_ovf_zero", 64'({overflow, zero}), 64'b10);
    issue(OP_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0);
    chk("addu_res_ovf", {31'd0, overflow, result}, 64'h8000_0000);
    issue(OP_SUB, 32'h8000_0000, 32'h1, 5'd0);
    chk("sub_res_ovf", {31'd0, overflow, result}, 64'h1_7FFF_FFFF);
    issue(OP_SUB, 32'd5, 32'd5, 5'd0);
    chk("sub_zero", {30'd0, overflow, zero, result}, 64'h1_0000_0000);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
    chk("slt", 64'(result), 64'd1);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0);
    chk("sltu", {31'd0, zero, result}, 64'h1_0000_0000);
    issue(OP_SRA, 32'h8000_0000, 32'h8000_0000, 5'd4);
    chk("sra", 64'(result), 64'hF800_0000);
    issue(OP_SLL, 32'h1, 32'h1, 5'd31);
    chk("sll", 64'(result), 64'h8000_0000);
    issue(OP_LUI, 32'h0, 32'h0000_1234, 5'd0);
    chk("lui", 64'(result), 64'h1234_0000);
    issue(OP_NOR, 32'h0F0F_0000, 32'h0000_00F0, 5'd0);
    chk("nor", 64'(result), 64'hF0F0_FF0F);

    // Back-to-back MTHI then MFHI.
    issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0, 5'd0);
    chk("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
    issue(OP_MFHI, 32'h0, 32'h0, 5'd0);
    chk("mfhi", 64'(result), 64'hDEAD_BEEF);
    issue(5'd25, 32'h1234, 32'h5678, 5'd0);
    chk("unused_op", {31'd0, out_valid, result}, 64'h1_0000_0000);
    chk("unused_hi", 64'(hi), 64'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("valid_drop", 64'(out_valid), 64'd0);
    chk("zero_hold", 64'(zero), 64'd1);

    mc(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, cyc, rh);
    chk("mult_latency", 64'(cyc), 64'd33);
    chk("mult_ready_low", 64'(rh), 64'd0);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("mult_result", 64'(result), 64'hFFFF_FFF1);
    issue(OP_MFHI, 32'h0, 32'h0, 5'd0);
    chk("mult_mfhi", 64'(result), 64'hFFFF_FFFF);

    mc(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc, rh);
    chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_dbz", 64'(dbz), 64'd0);
    mc(OP_DIVU, 32'd9, 32'd0, 1'b0, cyc, rh);
    chk("divu0_hilo", {hi, lo}, 64'h0000_0009_FFFF_FFFF);
    chk("divu0_dbz", 64'(dbz), 64'd1);
    mc(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc, rh);
    chk("div_min", {31'd0, dbz, hi, lo}, 64'h0000_0000_8000_0000);
    mc(OP_DIVU, 32'd100, 32'd7, 1'b0, cyc, rh);
    chk("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    // in_valid held with an MTHI during BUSY: must not be taken.
    mc(OP_MULTU, 32'd6, 32'd7, 1'b1, cyc, rh);
    chk("hold_hilo", {hi, lo}, 64'h0000_0000_0000_002A);
    chk("hold_latency", 64'(cyc), 64'd33);

    // Reset during BUSY: abort, HI/LO cleared, no completion.
    issue(OP_MULTU, 32'd7, 32'd7, 5'd0);
    seen = 0;
    repeat (9) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_ready", 64'(in_ready), 64'd1);
    chk("abort_hilo", {hi, lo}, 64'd0);
    repeat (40) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);

    // WIDTH = 16: MULTU 0xFFFF * 0xFFFF.
    op16 = OP_MULTU; a16 = 16'hFFFF; b16 = 16'hFFFF; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    cyc = 1;
    while (!ov16 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    chk("w16_latency", 64'(cyc), 64'd17);
    chk("w16_hilo", {32'd0, hi16, lo16}, 64'hFFFE_0001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised execute-stage ALU for the MIPS core, extending the combinational ALU with a registered result, a valid/ready issue handshake and an iterative multiply/divide unit with architectural HI/LO registers. It sits between the register-read stage and writeback. Single-cycle ops complete in one cycle; MULT/DIV ops stall issue for WIDTH+1 cycles.

## Interface
- WIDTH, 32: datapath width; ≥ 8, even.
- SHAMT_W, $clog2(WIDTH): shift-amount width.

- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  5  operation code, values from package.
- data1, data2  in  WIDTH  operands rs, rt.
- shamt  in  SHAMT_W  shift amount.
- out_valid  out  1  one-cycle pulse; result/flags valid.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0, registered.
- overflow  out  1  signed overflow on ADD/SUB, else 0.
- div_by_zero  out  1  DIV/DIVU with data2 == 0.
- hi, lo  out  WIDTH  architectural HI/LO registers.

## Operation
- Accept when in_valid && in_ready. Operands are captured at accept; inputs are ignored otherwise.
- Single-cycle ops (codes 0–15): ADD, ADDU, SUB, SUBU, AND, OR, NOR, XOR, SLL, SRL, SRA, SLT (signed), SLTU (unsigned), LUI (data2[WIDTH/2-1:0] << WIDTH/2), MFHI, MFLO. Codes 16–17 are MTHI and MTLO: result = data1, and hi/lo is written with data1.
- Multi-cycle ops (codes 18–21): MULT, MULTU, DIV, DIVU. These do not produce a GPR result: result = lo after update. Results go to {hi,lo}.
- overflow is set only for ADD/SUB:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign ≠ data1 sign.
- zero = (result == 0), independent of overflow.
- Multiply: shift-add on magnitudes, one bit per cycle, WIDTH iterations. MULT negates the 2·WIDTH product if the operand signs differ.
- Divide: restoring, one quotient bit per cycle. lo = quotient (truncated toward zero), hi = remainder carrying the dividend's sign.
  - Divide by zero: lo = all ones, hi = data1, div_by_zero = 1.
  - DIV of min / −1: lo = min, hi = 0, no flag.
- Unused op codes: result = 0, out_valid still pulses, hi/lo unchanged.
- States:
  - IDLE: in_ready = 1; a single-cycle op stays in IDLE, a multi-cycle op goes to BUSY.
  - BUSY: iteration counter runs WIDTH−1 → 0; goes to DONE when the counter reaches 0.
  - DONE: hi/lo written, out_valid = 1, then returns to IDLE.

## Timing
- Reset values: state IDLE, in_ready = 1, out_valid = 0, result = 0, zero = 0, overflow = 0, div_by_zero = 0, hi = 0, lo = 0, counter = 0.
- Single-cycle op accepted at edge T: out_valid, result and flags are valid in cycle T+1.
  - Back-to-back issue is allowed, one op per cycle.
  - An MTHI accepted at T is visible on hi from T+1, so an MFHI accepted at T+1 reads the new value.
- Multi-cycle op accepted at T:
  - BUSY for cycles T+1..T+WIDTH.
  - DONE in cycle T+WIDTH+1, with out_valid = 1 and hi/lo updated in that same cycle.
  - in_ready = 0 from T+1 through T+WIDTH+1; next accept at the edge ending T+WIDTH+2.
- out_valid is low in every cycle without a completion. flags hold their last value when out_valid = 0.
- Reset asserted mid-BUSY: the op is aborted, no out_valid is produced, and hi/lo are cleared.
- in_valid held during BUSY: not accepted, and no side effects.

## Structure
- Package alu_pkg holds:
  - op_t enum, 5 bits, with the codes above;
  - state_t {IDLE, BUSY, DONE};
  - helpers is_multicycle(op) and is_signed(op).
- Sub-module muldiv_iter(WIDTH) owns the counter, partial product/remainder and sign fix-up, and exposes start, done, hi_out and lo_out. Top level holds the single-cycle datapath, FSM and HI/LO.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → T+1: result 0x80000000, overflow 1, zero 0. ADDU of same operands → overflow 0.
- SUB 0x80000000 − 1 → result 0x7FFFFFFF, overflow 1. SUB 5 − 5 → result 0, zero 1.
- SLT 0xFFFFFFFF, 1 → 1. SLTU of same → 0. SRA 0x80000000 by 4 → 0xF8000000. LUI data2 = 0x1234 → 0x12340000.
- MULT −3 × 5 accepted at T:
  - in_ready low T+1..T+33;
  - at T+33: out_valid 1, hi 0xFFFFFFFF, lo 0xFFFFFFF1;
  - an MFHI next accepted returns 0xFFFFFFFF.
- DIV −7 / 2 → lo 0xFFFFFFFD, hi 0xFFFFFFFF. DIVU 9 / 0 → lo 0xFFFFFFFF, hi 9, div_by_zero 1.
- MULTU accepted, reset pulsed at T+10 → no out_valid, hi = lo = 0, in_ready 1 at T+11.
- WIDTH = 16 regression: MULTU 0xFFFF × 0xFFFF completes at T+17 with hi 0xFFFE, lo 0x0001.
